cgp_seq_sum_cmp: RTL
====================

# cgp_seq_sum_cmp

Streaming, parametrised successor of the combinational two-pair sum comparator used in the TNN decision nodes. It accepts one beat of LANES positive-side and LANES negative-side W-bit operands per handshake. Across a frame of up to BEATS beats it accumulates sum P (positive side) and sum N (negative side) exactly. It then emits a registered comparison flag, selected from four modes, together with the signed difference P−N. It sits between the feature-quantisation stage and the node-vote logic, and replaces the per-node fixed 2×3-bit comparator where features arrive serially.

## Interface
Parameters:
- W, 3, operand width (unsigned), ≥1
- LANES, 2, operands per side per beat, ≥1
- BEATS, 4, maximum beats per frame, ≥1
- Derived: AW = W + clog2(LANES) + clog2(BEATS) (accumulator width; clog2(1)=0); DW = AW+1 (signed difference)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  beat offered
- in_ready  out  1  block can accept a beat
- in_p  in  LANES*W  positive-side operands, lane i at [i*W +: W]
- in_n  in  LANES*W  negative-side operands, same packing
- in_last  in  1  closes the frame early on this beat
- cmp_mode  in  2  00 P>N, 01 P≥N, 10 P==N, 11 P<N; sampled on the closing beat
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_flag  out  1  comparison result
- out_diff  out  DW  P−N, two's complement

## Operation
- FSM states are ACCUM and HOLD. Reset enters ACCUM with the accumulators and beat counter at 0.
- ACCUM: in_ready=1. A beat is accepted when in_valid && in_ready.
  - On each accepted beat: accP += Σ in_p lanes and accN += Σ in_n lanes. The lane sums are zero-extended to AW. Arithmetic is exact, with no truncation or approximation.
  - A beat closes the frame if in_last=1 or it is beat number BEATS (counter == BEATS−1).
  - On a closing beat:
    - out_flag and out_diff are registered from the updated sums using the cmp_mode value present on that beat.
    - accP, accN and the counter are cleared.
    - The FSM goes to HOLD.
  - On a non-closing beat, the counter increments.
- HOLD: in_ready=0 and out_valid=1. out_flag and out_diff are stable until out_valid && out_ready. On that handshake the FSM returns to ACCUM and out_valid clears in the same edge.
- Operand values are unconstrained. The worst case LANES*BEATS*(2^W−1) fits in AW bits.
- cmp_mode changes on non-closing beats have no effect.
- BEATS=1: every accepted beat closes a frame.

## Timing
- Reset values (asynchronous, immediate): out_valid=0, out_flag=0, out_diff=0, in_ready=1, accumulators=0, counter=0.
- Latency: out_valid rises on the clock edge that accepts the closing beat, so the result is visible the following cycle.
- There is no bypass. After the output handshake, in_ready returns to 1 one cycle later. Maximum throughput is therefore one frame per (beats + 1) cycles.
- in_ready depends only on state, with no combinational path from out_ready.
- If rst asserts mid-frame or in HOLD, the partial sums and any pending result are discarded and the next frame starts from zero.
- in_p, in_n, in_last and cmp_mode are don't-care when in_valid=0.

## Test plan
With W=3, LANES=2, BEATS=4 (AW=6, DW=7):
- Full frame: 4 beats of p={3,4}, n={2,2}, mode 00 -> out_valid one cycle after the 4th accept, out_flag=1, out_diff=+12 (28−16).
- Equality across modes: 4 beats of p={7,0}, n={3,4}, repeated for modes 00/01/10/11 -> out_flag 0/1/1/0, out_diff=0.
- Early close: beat 1 p={1,1}, n={2,2}, then beat 2 the same with in_last=1, mode 11 -> out_flag=1, out_diff=−4. The next frame starts with the counter at 0.
- Backpressure: hold out_ready=0 for 5 cycles after a result -> in_ready=0 and out_flag/out_diff stable throughout. After the handshake, in_ready=1 on the next cycle and no beat is lost.
- Extremes: 4 beats of all-7 versus all-0 -> out_diff=+56. Swapping the sides gives out_diff=−56, with no overflow.
- Reset mid-frame: accept 2 beats of p={7,7}, pulse rst, then run a fresh frame of 4 beats of p={1,0}, n={0,0} -> out_diff=+4 and out_valid=0 immediately on rst assertion.

Source files
------------

// File: rtl/cgp_seq_sum_cmp.sv
// Streaming two-sided sum comparator: accumulates LANES positive and negative
// operands per beat over a frame of up to BEATS beats, then holds flag and P-N.
module cgp_seq_sum_cmp #(
  parameter int W     = 3,
  parameter int LANES = 2,
  parameter int BEATS = 4,
  localparam int AW   = W + $clog2(LANES) + $clog2(BEATS),
  localparam int DW   = AW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*W-1:0]   in_p,
  input  logic [LANES*W-1:0]   in_n,
  input  logic                 in_last,
  input  logic [1:0]           cmp_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_flag,
  output logic [DW-1:0]        out_diff
);

  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   acc_p_q, acc_n_q;
  logic [CW-1:0]   cnt_q;
  logic [AW-1:0]   sum_p, sum_n;
  logic [AW-1:0]   acc_p_next, acc_n_next;
  logic [DW-1:0]   diff_next;
  logic            flag_next;
  logic            accept, closing;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready and out_valid are decoded from state only, so there is no
  // combinational path from out_ready to in_ready.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && closing) state_d = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  assign accept  = in_valid && in_ready;
  assign closing = in_last || (cnt_q == CW'(BEATS - 1));

  always_comb begin
    sum_p = '0;
    sum_n = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_p = sum_p + AW'(in_p[i*W +: W]);
      sum_n = sum_n + AW'(in_n[i*W +: W]);
    end
  end

  assign acc_p_next = acc_p_q + sum_p;
  assign acc_n_next = acc_n_q + sum_n;
  // One extra bit keeps the unsigned subtraction a correct two's-complement P-N.
  assign diff_next  = DW'(acc_p_next) - DW'(acc_n_next);

  always_comb begin
    flag_next = 1'b0;
    case (cmp_mode)
      2'b00: flag_next = (acc_p_next >  acc_n_next);
      2'b01: flag_next = (acc_p_next >= acc_n_next);
      2'b10: flag_next = (acc_p_next == acc_n_next);
      2'b11: flag_next = (acc_p_next <  acc_n_next);
      default: flag_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ACCUM;
      acc_p_q  <= '0;
      acc_n_q  <= '0;
      cnt_q    <= '0;
      out_flag <= 1'b0;
      out_diff <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        if (closing) begin
          out_flag <= flag_next;
          out_diff <= diff_next;
          acc_p_q  <= '0;
          acc_n_q  <= '0;
          cnt_q    <= '0;
        end else begin
          acc_p_q  <= acc_p_next;
          acc_n_q  <= acc_n_next;
          cnt_q    <= cnt_q + CW'(1);
        end
      end
    end
  end

endmodule
